// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ writers.
// Optional per-requester accepted-beat counters when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DW-1:0]        din,
    output logic [NREQ-1:0]           gnt,
    input  logic                      fifo_full,
    output logic                      fifo_wn,
    output logic [DW-1:0]             fifo_din,
    output logic [$clog2(NREQ)-1:0]   owner
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]        stat_beats
`endif
);

    localparam int OW = $clog2(NREQ);
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NREQ-1:0] r_gnt;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   r_last;
    logic [BW-1:0]   r_beat;
    logic [OW-1:0]   w_pick;
    logic            w_found;
    logic            w_any_req;
    logic            w_owner_req;
    logic            w_accept;
    logic            w_release;

    assign w_any_req   = |req;
    assign w_owner_req = req[r_owner];
    // reset gates the write so an in-flight beat is dropped without waiting for a clock
    assign w_accept    = reset & (r_state == S_BURST) & w_owner_req & ~fifo_full;
    assign w_release   = (r_state == S_BURST) &
                         (~w_owner_req | (w_accept & (r_beat == BW'(BURST - 1))));

    // Round-robin search starting just after the last served requester
    always_comb begin
        w_pick  = r_last;
        w_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(r_last) + k) % NREQ;
            if (!w_found && req[idx]) begin
                w_pick  = OW'(idx);
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = w_any_req ? S_BURST : S_IDLE;
            S_BURST: w_state_nxt = w_release ? S_IDLE : S_BURST;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Grant, owner, last-served pointer and beat counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_gnt   <= {NREQ{1'b0}};
            r_owner <= {OW{1'b0}};
            r_last  <= OW'(NREQ - 1);
            r_beat  <= {BW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_pick;
                        r_gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
                        r_beat  <= {BW{1'b0}};
                    end else begin
                        r_gnt   <= {NREQ{1'b0}};
                    end
                end
                S_BURST: begin
                    if (w_release) begin
                        r_gnt  <= {NREQ{1'b0}};
                        r_last <= r_owner;
                    end else if (w_accept) begin
                        r_beat <= r_beat + {{(BW-1){1'b0}}, 1'b1};
                    end else begin
                        r_beat <= r_beat;
                    end
                end
                default: begin
                    r_gnt <= {NREQ{1'b0}};
                end
            endcase
        end
    end

    // FIFO write-side outputs
    always_comb begin
        fifo_wn  = w_accept;
        fifo_din = din[r_owner*DW +: DW];
    end

    assign gnt   = r_gnt;
    assign owner = r_owner;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] r_stat [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        // Saturating count of beats accepted from requester g
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_stat[g] <= 16'h0000;
            end else if (w_accept && (r_owner == OW'(g)) && (r_stat[g] != 16'hFFFF)) begin
                r_stat[g] <= r_stat[g] + 16'h0001;
            end else begin
                r_stat[g] <= r_stat[g];
            end
        end
        assign stat_beats[g*16 +: 16] = r_stat[g];
    end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

- Round-robin arbiter that shares the single write port of the team's synchronous FIFO (8-bit `DATAIN`, `wn`, `full`) among `NREQ` independent writers.
- Each grant is a burst of up to `BURST` beats, so a writer's bytes stay contiguous in the FIFO.
- Sits directly in front of the FIFO write side; the FIFO read side is untouched.

## Interface
Parameters:
- `NREQ`, 4 — number of requesters, 2..8.
- `DW`, 8 — data width; must match the FIFO `DATAIN` width.
- `BURST`, 4 — maximum accepted beats per grant, ≥1.

Ports:
- `clock` input, 1 — single clock; all state updates on rising edge.
- `reset` input, 1 — asynchronous, active-low; asserting it (0) clears all state immediately.
- `req` input, NREQ — `req[i]` high: requester i has a valid byte on its `din` slice.
- `din` input, NREQ*DW — flat data; requester i at `[i*DW +: DW]`.
- `gnt` output, NREQ — one-hot registered grant, or all-zero.
- `fifo_full` input, 1 — FIFO `full` flag.
- `fifo_wn` output, 1 — FIFO write enable.
- `fifo_din` output, DW — FIFO write data.
- `owner` output, clog2(NREQ) — index of the current grant holder; valid only while `gnt` is non-zero.

## Operation
State machine, two states: IDLE and BURST.

Reset values (any time `reset` = 0):
- state = IDLE, `gnt` = 0, `owner` = 0, beat counter = 0.
- last-served pointer = NREQ-1, so requester 0 has first priority.
- `fifo_wn` = 0.

IDLE:
- If `req` ≠ 0, search from (last+1) mod NREQ upward with wrap-around; pick the first requester with `req` high.
- Load `owner`, set `gnt` = onehot(owner), clear the beat counter, go to BURST.
- If `req` = 0, stay in IDLE with `gnt` = 0.

BURST:
- Combinational: accept = `req[owner]` & ~`fifo_full`.
- `fifo_wn` = accept; `fifo_din` = `din` slice of `owner`. `fifo_din` is muxed from `owner` even when not writing.
- Each accept increments the beat counter.
- Release to IDLE (`gnt` ← 0, last ← `owner`) at the clock edge where either:
  - accept occurs and the beat counter equals BURST-1, or
  - `req[owner]` = 0.
- Otherwise remain in BURST.

Boundary rules:
- `fifo_full` high: no accept and no beat counted; the grant is held indefinitely; other requesters wait.
- Owner drops `req` mid-burst: no write that cycle; grant released; pointer advances past it.
- Simultaneous requests: round-robin order guarantees each active requester is granted within NREQ grants.
- A non-owner `req` toggling during BURST has no effect.
- Reset mid-burst: the write in flight is not issued. `fifo_wn` goes 0 asynchronously.

## Timing
- Grant latency: `req` seen high at edge N in IDLE → `gnt` high after edge N; first possible write in cycle N+1.
- One IDLE bubble cycle between consecutive grants, including back-to-back grants to the same requester.
- Sustained throughput with the FIFO never full: BURST beats per BURST+1 cycles.
- Requester handshake: the byte is consumed in the cycle where `gnt[i]` & `req[i]` & ~`fifo_full`. The requester must hold `din` stable until that cycle, and may present its next byte in the following cycle.
- No combinational path from `fifo_full` or `req` to `gnt`; paths to `fifo_wn` and `fifo_din` exist, through a single AND and the mux only.

## Configuration
- `FIFO_ARB_STATS_EN` defined:
  - Adds output `stat_beats` [NREQ*16-1:0].
  - Per-requester 16-bit counter of accepted beats; saturates at 0xFFFF; cleared by `reset`.
- Not defined: port and counters absent. Arbitration behaviour is identical in both builds.

## Test plan
- Reset, single writer: hold `reset`=0, then release; `req`=0001 with bytes 0xA0..0xA5 → `gnt`=0001 one cycle later; FIFO receives 0xA0–0xA3; one idle cycle; re-grant; 0xA4, 0xA5 follow.
- All four requesting continuously, FIFO never full → grant order 0,1,2,3,0…; 4 beats each; `fifo_wn` pattern 4 high / 1 low.
- Backpressure: `fifo_full`=1 for 3 cycles mid-burst of requester 2 → `fifo_wn`=0, `gnt`=0100 held, beat count unchanged; burst completes after `full` drops.
- Early release: requester 1 drops `req` after 2 beats while 3 is waiting → `gnt` 0010→0000→1000; next winner is 3, not 2.
- Reset mid-burst: assert `reset` during beat 2 → `gnt`, `fifo_wn` = 0 immediately; after release, requester 0 is first served.
- With `FIFO_ARB_STATS_EN`: 10 beats from requester 3 → `stat_beats[63:48]` = 10, other counters 0.
